// File: rtl/exh_sweep_engine.sv
// exh_sweep_engine
//   Exhaustive-stimulus sequencer with response capture. Walks every
//   N_WIDTH-bit input vector in binary or Gray order. Each vector is held for
//   HOLD_CYCLES cycles, and then the DUT response is sampled. The
//   {vector, response} record is offered on a valid/ready port, and every
//   response is folded into a MISR signature.
//
// Ports
//   CK         in   clock, all state updates on the rising edge
//   reset      in   synchronous active-low reset
//   start      in   begin a sweep (honoured in IDLE or DONE only)
//   abort      in   terminate a running sweep, return to IDLE
//   dut_out    in   [OUT_WIDTH]  DUT response
//   stim       out  [N_WIDTH]    vector driven to the DUT
//   busy       out  high while applying or capturing
//   cap_valid  out  capture record valid
//   cap_ready  in   logger accepts the record
//   cap_vec    out  [N_WIDTH]    vector of the current record
//   cap_resp   out  [OUT_WIDTH]  sampled response
//   done       out  sweep complete, held until next start or reset
//   signature  out  [SIG_WIDTH]  MISR value
module exh_sweep_engine #(
  parameter int unsigned             N_WIDTH     = 7,
  parameter int unsigned             OUT_WIDTH   = 1,
  parameter int unsigned             HOLD_CYCLES = 1,
  parameter int unsigned             GRAY_MODE   = 0,
  parameter int unsigned             SIG_WIDTH   = 16,
  parameter logic [SIG_WIDTH-1:0]    SIG_POLY    = 16'h1021,
  parameter logic [SIG_WIDTH-1:0]    SIG_SEED    = 16'hFFFF
) (
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [OUT_WIDTH-1:0] dut_out,
  output logic [N_WIDTH-1:0]   stim,
  output logic                 busy,
  output logic                 cap_valid,
  input  logic                 cap_ready,
  output logic [N_WIDTH-1:0]   cap_vec,
  output logic [OUT_WIDTH-1:0] cap_resp,
  output logic                 done,
  output logic [SIG_WIDTH-1:0] signature
);

  localparam int unsigned HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);
  localparam logic [N_WIDTH:0] IDX_LAST = {1'b0, {N_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [N_WIDTH:0]   idx;
  logic [N_WIDTH:0]   idx_nxt;
  logic [HCW-1:0]     hold;
  logic               launch;
  logic               capture;
  logic               accept;
  logic               kill;
  logic               last;

  function automatic logic [N_WIDTH-1:0] vec_of(input logic [N_WIDTH-1:0] i);
    return (GRAY_MODE != 0) ? (i ^ (i >> 1)) : i;
  endfunction

  function automatic logic [SIG_WIDTH-1:0] misr_next(input logic [SIG_WIDTH-1:0] s,
                                                     input logic [SIG_WIDTH-1:0] d);
    return {s[SIG_WIDTH-2:0], 1'b0} ^ (s[SIG_WIDTH-1] ? SIG_POLY : '0) ^ d;
  endfunction

  assign idx_nxt = idx + 1'b1;
  assign last    = (idx == IDX_LAST);

  always_ff @(posedge CK) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // abort has priority over every other transition, including start in IDLE/DONE
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    kill       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          state_next = S_APPLY;
          launch     = 1'b1;
        end
      end
      S_APPLY: begin
        if (abort) begin
          state_next = S_IDLE;
          kill       = 1'b1;
        end else if (hold == '0) begin
          state_next = S_CAPTURE;
          capture    = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (abort) begin
          state_next = S_IDLE;
          kill       = 1'b1;
        end else if (cap_valid && cap_ready) begin
          accept     = 1'b1;
          state_next = last ? S_DONE : S_APPLY;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (!reset) begin
      stim      <= '0;
      cap_vec   <= '0;
      cap_resp  <= '0;
      idx       <= '0;
      hold      <= '0;
      cap_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      signature <= SIG_SEED;
    end else begin
      busy <= (state_next == S_APPLY) || (state_next == S_CAPTURE);
      done <= (state_next == S_DONE);

      if (state == S_APPLY && hold != '0) begin
        hold <= hold - 1'b1;
      end

      if (launch) begin
        idx       <= '0;
        stim      <= vec_of('0);
        signature <= SIG_SEED;
        hold      <= HOLD_LOAD;
      end

      // stim still holds the vector being sampled, so it doubles as cap_vec here
      if (capture) begin
        cap_resp  <= dut_out;
        cap_vec   <= stim;
        cap_valid <= 1'b1;
        signature <= misr_next(signature, SIG_WIDTH'({stim, dut_out}));
      end

      if (accept) begin
        cap_valid <= 1'b0;
        if (!last) begin
          idx  <= idx_nxt;
          stim <= vec_of(idx_nxt[N_WIDTH-1:0]);
          hold <= HOLD_LOAD;
        end
      end

      if (kill) begin
        cap_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/exh_sweep_engine.md
# exh_sweep_engine

Synthesizable exhaustive-stimulus sequencer with response capture for trojan-detection benchmark DUTs. It drives every input vector of a parameterised-width DUT in binary or Gray order, holding each vector for a configurable number of cycles. After the hold it samples the DUT response and presents a {vector, response} record to a downstream logger through a valid/ready handshake. It also compacts all responses into a MISR signature, so a golden-vs-suspect comparison needs only one word.

## Interface
- N_WIDTH, 7: DUT input width; sweep length is 2^N_WIDTH vectors.
- OUT_WIDTH, 1: DUT response width.
- HOLD_CYCLES, 1: cycles each vector is applied before sampling, ≥1.
- GRAY_MODE, 0: 0 = binary count order; 1 = Gray order, vector = idx ^ (idx >> 1).
- SIG_WIDTH, 16: MISR width; must be ≥ N_WIDTH+OUT_WIDTH.
- SIG_POLY, 16'h1021: MISR feedback polynomial.
- SIG_SEED, 16'hFFFF: MISR value loaded on start.
- CK  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- abort  in  1  terminate the sweep; return to IDLE.
- dut_out  in  OUT_WIDTH  DUT response.
- stim  out  N_WIDTH  vector driven to DUT.
- busy  out  1  high in APPLY or CAPTURE.
- cap_valid  out  1  capture record valid.
- cap_ready  in  1  logger accepts record.
- cap_vec  out  N_WIDTH  vector of the current record.
- cap_resp  out  OUT_WIDTH  sampled response.
- done  out  1  sweep complete; level, held until the next start or reset.
- signature  out  SIG_WIDTH  MISR value.

## Operation
- States: IDLE, APPLY, CAPTURE, DONE.
- Reset (reset==0 at an edge), from any state: state=IDLE. stim, cap_vec, cap_resp, idx and hold counter = 0. cap_valid, busy, done = 0. signature = SIG_SEED.
- IDLE/DONE + start:
  - Go to APPLY.
  - Set idx=0, stim=vec(0), signature=SIG_SEED, done=0.
  - Load the hold counter with HOLD_CYCLES-1.
- APPLY:
  - Decrement the hold counter each cycle.
  - At the edge where the counter is 0:
    - cap_resp ← dut_out, cap_vec ← stim, cap_valid ← 1.
    - signature ← MISR(signature, {cap_vec, dut_out} zero-extended to SIG_WIDTH).
    - Go to CAPTURE.
- MISR(s, d) = ((s << 1) ^ (s[MSB] ? SIG_POLY : 0)) ^ d, truncated to SIG_WIDTH. It updates exactly once per vector, in the capture cycle, never on backpressure cycles.
- CAPTURE: stim, cap_vec, cap_resp are stable while cap_valid && !cap_ready. When cap_valid && cap_ready:
  - cap_valid ← 0.
  - If idx == 2^N_WIDTH-1: go to DONE, done ← 1, stim holds its last vector.
  - Otherwise: idx ← idx+1, stim ← vec(idx+1), reload the hold counter, go to APPLY.
- idx is N_WIDTH+1 bits wide internally so the terminal compare never wraps. vec() wraps naturally within N_WIDTH.
- abort in APPLY/CAPTURE: go to IDLE next edge, cap_valid ← 0, done stays 0, signature is frozen at its current value.
- abort wins over start on the same edge. start during APPLY/CAPTURE is ignored.
- cap_ready is ignored when cap_valid == 0.

## Timing
- Edge 0 is the edge that samples start. stim = vec(0) from edge 0.
- With cap_ready held high:
  - Vector i is applied from edge i·(HOLD_CYCLES+1).
  - Its record is valid for the single cycle following edge i·(HOLD_CYCLES+1)+HOLD_CYCLES.
  - done rises after edge 2^N_WIDTH·(HOLD_CYCLES+1).
- Each cycle of backpressure delays all later events by exactly one cycle.
- dut_out is sampled HOLD_CYCLES edges after stim changes. The DUT combinational path must settle within HOLD_CYCLES clock periods.
- Outputs are registered; there is no combinational path from any input to any output.

## Test plan
- N_WIDTH=7, HOLD_CYCLES=1, binary, cap_ready=1, dut_out=stim[0]:
  - 128 records with cap_vec = 0..127 in order and cap_resp = cap_vec[0].
  - done rises after edge 256; busy falls on the same edge.
- N_WIDTH=3, GRAY_MODE=1, HOLD_CYCLES=3:
  - cap_vec sequence is 0,1,3,2,6,7,5,4.
  - Records spaced 4 cycles apart; done after edge 32.
- Backpressure: N_WIDTH=3, cap_ready low for 5 cycles on record 2:
  - stim=2, cap_vec=2, cap_resp stable and cap_valid high throughout.
  - signature changes only once for that record; done is delayed by exactly 5 cycles.
- Signature:
  - Two identical runs give identical signature.
  - Flipping dut_out on vector 5 only gives a different signature.
  - A new start reloads 16'hFFFF.
- Abort and reset mid-sweep:
  - abort during vector 10: IDLE next edge, cap_valid=0, done=0; a restart begins at vec(0).
  - reset=0 during CAPTURE: all outputs at reset values after that edge.
  - start and abort on the same edge in IDLE: state stays IDLE.
